// File: rtl/jet_argmax_out.sv
// ============================================================================
// Module      : jet_argmax_out
// Description : Output stage for the polylut_add jet core. Aligns in_valid to
//               the core latency, registers the signed argmax of the packed
//               class scores and buffers results in an FWFT FIFO.
//               Optional macro ARGMAX_MARGIN_EN adds out_margin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jet_argmax_out #(
    parameter int NUM_CLASSES = 5,
    parameter int SCORE_W     = 5,
    parameter int CORE_LAT    = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [NUM_CLASSES*SCORE_W-1:0]     scores,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]     out_class,
    output logic [SCORE_W-1:0]                 out_score,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic [15:0]                        drop_cnt
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [SCORE_W:0]                   out_margin
`endif
);

    localparam int c_CLS_W = $clog2(NUM_CLASSES);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    // ---------------- valid alignment ----------------
    logic [CORE_LAT-1:0] r_vdly;
    logic                w_s_valid;

    generate
        if (CORE_LAT == 1) begin : g_dly_one
            always_ff @(posedge clk) begin
                if (rst) r_vdly <= '0;
                else     r_vdly <= in_valid;
            end
        end else begin : g_dly_multi
            always_ff @(posedge clk) begin
                if (rst) r_vdly <= '0;
                else     r_vdly <= {r_vdly[CORE_LAT-2:0], in_valid};
            end
        end
    endgenerate

    assign w_s_valid = r_vdly[CORE_LAT-1];

    // ---------------- argmax ----------------
    logic signed [SCORE_W-1:0] w_score [NUM_CLASSES];

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
            assign w_score[gi] = scores[gi*SCORE_W +: SCORE_W];
        end
    endgenerate

    logic signed [SCORE_W-1:0] w_best;
    logic [c_CLS_W-1:0]        w_best_idx;

    // Strict greater-than keeps the lowest index on ties
    always_comb begin
        w_best     = w_score[0];
        w_best_idx = '0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (w_score[i] > w_best) begin
                w_best     = w_score[i];
                w_best_idx = c_CLS_W'(i);
            end
        end
    end

    logic                      r_a_valid;
    logic [c_CLS_W-1:0]        r_a_class;
    logic [SCORE_W-1:0]        r_a_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_class <= '0;
            r_a_score <= '0;
        end else begin
            r_a_valid <= w_s_valid;
            if (w_s_valid) begin
                r_a_class <= w_best_idx;
                r_a_score <= w_best;
            end
        end
    end

`ifdef ARGMAX_MARGIN_EN
    logic signed [SCORE_W-1:0] w_second;
    logic [SCORE_W:0]          w_margin;
    logic [SCORE_W:0]          r_a_margin;

    // Runner-up is the largest score among every class except the winner
    always_comb begin
        w_second = {1'b1, {(SCORE_W-1){1'b0}}};
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if ((c_CLS_W'(i) != w_best_idx) && (w_score[i] > w_second))
                w_second = w_score[i];
        end
        w_margin = {w_best[SCORE_W-1], w_best} - {w_second[SCORE_W-1], w_second};
    end

    always_ff @(posedge clk) begin
        if (rst)            r_a_margin <= '0;
        else if (w_s_valid) r_a_margin <= w_margin;
    end
`endif

    // ---------------- result FIFO ----------------
    logic [c_CLS_W-1:0] r_mem_class [FIFO_DEPTH];
    logic [SCORE_W-1:0] r_mem_score [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [15:0]        r_drop_cnt;
    logic               w_nonempty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_nonempty = (r_level != '0);
    assign w_full     = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_pop      = w_nonempty && out_ready;
    assign w_push     = r_a_valid && (!w_full || w_pop);
    assign w_drop     = r_a_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_class[r_wr_ptr] <= r_a_class;
            r_mem_score[r_wr_ptr] <= r_a_score;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Head is forced to zero when empty so stale memory never shows
    assign out_valid  = w_nonempty;
    assign out_class  = w_nonempty ? r_mem_class[r_rd_ptr] : '0;
    assign out_score  = w_nonempty ? r_mem_score[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop_cnt;

`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W:0] r_mem_margin [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) r_mem_margin[r_wr_ptr] <= r_a_margin;
    end

    assign out_margin = w_nonempty ? r_mem_margin[r_rd_ptr] : '0;
`endif

endmodule

`default_nettype wire
